// File: rtl/edit_field_sequencer_if.sv
// Front-panel bundle between the button conditioner and the edit sequencer.
// The panel side drives button levels; the sequencer returns field select and steps.
interface edit_field_sequencer_if;
    logic       btn_prog;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic [1:0] group_sel;
    logic [3:0] en_count;
    logic       enUP;
    logic       enDOWN;
    logic       edit_active;

    modport master (
        output btn_prog, btn_left, btn_right, btn_up, btn_down, group_sel,
        input  en_count, enUP, enDOWN, edit_active
    );

    modport slave (
        input  btn_prog, btn_left, btn_right, btn_up, btn_down, group_sel,
        output en_count, enUP, enDOWN, edit_active
    );
endinterface

// File: rtl/edit_field_sequencer.sv
// Edit-mode controller: field select plus up/down step pulses with
// hold-to-repeat and an inactivity timeout, all in the system clock domain.
module edit_field_sequencer #(
    parameter int unsigned HOLD_CYCLES    = 50_000_000,
    parameter int unsigned REPEAT_CYCLES  = 26_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
    input logic                   clk,
    input logic                   reset,
    edit_field_sequencer_if.slave bus
);
    localparam logic [31:0] HOLD_M1 = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] REP_M1  = 32'(REPEAT_CYCLES - 1);
    localparam logic [31:0] TO_M1   = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, EDIT} state_e;

    state_e      state_q, state_d;
    logic [1:0]  group_q, group_d;
    logic [1:0]  fidx_q, fidx_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] to_q, to_d;
    logic        armed_q, armed_d;
    logic        first_q, first_d;
    logic        supp_q, supp_d;
    logic [4:0]  prev_q;
    logic [4:0]  btn;
    logic [4:0]  rise;
    logic [31:0] rep_lim;
    logic        up_d, dn_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        up_q, dn_q, act_q;

    // bit order: prog, left, right, up, down
    assign btn  = {bus.btn_prog, bus.btn_left, bus.btn_right,
                   bus.btn_up, bus.btn_down};
    assign rise = btn & ~prev_q;

    function automatic logic [3:0] code(input logic [1:0] g,
                                        input logic [1:0] f);
        unique case (g)
            2'd0:    code = 4'd1 + {2'b00, f};
            2'd1:    code = 4'd4 + {2'b00, f};
            default: code = 4'd8 + {2'b00, f};
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        group_d = group_q;
        fidx_d  = fidx_q;
        hold_d  = hold_q;
        to_d    = to_q;
        armed_d = armed_q;
        first_d = first_q;
        supp_d  = supp_q;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        rep_lim = first_q ? HOLD_M1 : REP_M1;
        unique case (state_q)
            IDLE: begin
                to_d    = '0;
                hold_d  = '0;
                armed_d = 1'b0;
                supp_d  = 1'b0;
                if (rise[4] && bus.group_sel != 2'd3) begin
                    state_d = EDIT;
                    group_d = bus.group_sel;
                    fidx_d  = 2'd0;
                end
            end
            EDIT: begin
                if (rise[4] || to_q == TO_M1) begin
                    state_d = IDLE;
                    to_d    = '0;
                    hold_d  = '0;
                    armed_d = 1'b0;
                    supp_d  = 1'b0;
                end else begin
                    if (rise[2] ^ rise[3]) begin
                        if (rise[2])
                            fidx_d = (fidx_q == 2'd2) ? 2'd0 : fidx_q + 2'd1;
                        else
                            fidx_d = (fidx_q == 2'd0) ? 2'd2 : fidx_q - 2'd1;
                        armed_d = 1'b0;
                        hold_d  = '0;
                        supp_d  = 1'b1;
                    end else if (supp_q) begin
                        if (!btn[1] && !btn[0])
                            supp_d = 1'b0;
                    end else if (btn[1] && btn[0]) begin
                        armed_d = 1'b0;
                        hold_d  = '0;
                    end else if (rise[1] || rise[0]) begin
                        up_d    = rise[1];
                        dn_d    = rise[0];
                        armed_d = 1'b1;
                        first_d = 1'b1;
                        hold_d  = '0;
                    end else if (armed_q && (btn[1] || btn[0])) begin
                        if (hold_q == rep_lim) begin
                            up_d    = btn[1];
                            dn_d    = btn[0];
                            hold_d  = '0;
                            first_d = 1'b0;
                        end else begin
                            hold_d = hold_q + 32'd1;
                        end
                    end else begin
                        armed_d = 1'b0;
                        hold_d  = '0;
                    end
                    to_d = (|rise[3:0] || up_d || dn_d) ? '0 : to_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d == EDIT) ? code(group_d, fidx_d) : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            group_q <= 2'd0;
            fidx_q  <= 2'd0;
            hold_q  <= '0;
            to_q    <= '0;
            armed_q <= 1'b0;
            first_q <= 1'b0;
            supp_q  <= 1'b0;
            prev_q  <= '1;
            cnt_q   <= 4'd0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            group_q <= group_d;
            fidx_q  <= fidx_d;
            hold_q  <= hold_d;
            to_q    <= to_d;
            armed_q <= armed_d;
            first_q <= first_d;
            supp_q  <= supp_d;
            prev_q  <= btn;
            cnt_q   <= cnt_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            act_q   <= (state_d == EDIT);
        end
    end

    assign bus.en_count    = cnt_q;
    assign bus.enUP        = up_q;
    assign bus.enDOWN      = dn_q;
    assign bus.edit_active = act_q;
endmodule

// File: tb/tb_edit_field_sequencer.sv
// Scoreboard bench: stimulus queues expected output events with their edge,
// a monitor pops one whenever a pulse or field/mode change appears.
module tb_edit_field_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    typedef struct {
        int         at;
        logic [3:0] cnt;
        logic       up;
        logic       dn;
        logic       act;
    } ev_t;

    ev_t q[$];

    edit_field_sequencer_if ifc ();

    edit_field_sequencer #(
        .HOLD_CYCLES   (8),
        .REPEAT_CYCLES (4),
        .TIMEOUT_CYCLES(40)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ev(input int d, input logic [3:0] c,
                      input logic u, input logic dn, input logic a);
        ev_t e;
        e.at = cyc + d;
        e.cnt = c;
        e.up = u;
        e.dn = dn;
        e.act = a;
        q.push_back(e);
    endtask

    initial begin : monitor
        logic [3:0] last_cnt;
        logic       last_act;
        ev_t        e;
        last_cnt = 4'd0;
        last_act = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (ifc.enUP || ifc.enDOWN || ifc.en_count != last_cnt ||
                    ifc.edit_active != last_act) begin
                    n_cmp++;
                    if (q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_event edge=%0d cnt=%0d up=%0b dn=%0b act=%0b",
                                 cyc, ifc.en_count, ifc.enUP, ifc.enDOWN, ifc.edit_active);
                    end else begin
                        e = q.pop_front();
                        if (e.at != cyc || e.cnt != ifc.en_count || e.up != ifc.enUP ||
                            e.dn != ifc.enDOWN || e.act != ifc.edit_active) begin
                            n_bad++;
                            $display("FAIL event got edge=%0d cnt=%0d up=%0b dn=%0b act=%0b want edge=%0d cnt=%0d up=%0b dn=%0b act=%0b",
                                     cyc, ifc.en_count, ifc.enUP, ifc.enDOWN, ifc.edit_active,
                                     e.at, e.cnt, e.up, e.dn, e.act);
                        end
                    end
                end
                last_cnt = ifc.en_count;
                last_act = ifc.edit_active;
            end
        end
    end

    initial begin : stim
        ev_t        e;
        logic [3:0] rcodes [3];
        rcodes = '{4'd9, 4'd10, 4'd8};
        reset = 1'b1;
        ifc.btn_prog = 1'b0;
        ifc.btn_left = 1'b0;
        ifc.btn_right = 1'b0;
        ifc.btn_up = 1'b0;
        ifc.btn_down = 1'b0;
        ifc.group_sel = 2'd0;
        tick(2);
        n_cmp++;
        if (ifc.en_count !== 4'd0 || ifc.enUP !== 1'b0 ||
            ifc.enDOWN !== 1'b0 || ifc.edit_active !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state got cnt=%0d up=%0b dn=%0b act=%0b want all 0",
                     ifc.en_count, ifc.enUP, ifc.enDOWN, ifc.edit_active);
        end
        reset = 1'b0;
        mon_en = 1'b1;
        tick(2);

        // timer group entry and right-walk with wrap
        ifc.group_sel = 2'd2;
        ifc.btn_prog = 1'b1;
        ev(1, 4'd8, 1'b0, 1'b0, 1'b1);
        tick(1);
        ifc.btn_prog = 1'b0;
        tick(1);
        for (int i = 0; i < 3; i++) begin
            ifc.btn_right = 1'b1;
            ev(1, rcodes[i], 1'b0, 1'b0, 1'b1);
            tick(1);
            ifc.btn_right = 1'b0;
            tick(1);
        end

        // hold up 20 cycles: pulses at N, N+8, N+12, N+16
        ifc.btn_up = 1'b1;
        ev(1, 4'd8, 1'b1, 1'b0, 1'b1);
        ev(9, 4'd8, 1'b1, 1'b0, 1'b1);
        ev(13, 4'd8, 1'b1, 1'b0, 1'b1);
        ev(17, 4'd8, 1'b1, 1'b0, 1'b1);
        tick(20);
        ifc.btn_up = 1'b0;
        tick(2);

        // up and down together, then release one, then fresh up press
        ifc.btn_up = 1'b1;
        ifc.btn_down = 1'b1;
        tick(3);
        ifc.btn_down = 1'b0;
        tick(3);
        ifc.btn_up = 1'b0;
        tick(1);
        ifc.btn_up = 1'b1;
        ev(1, 4'd8, 1'b1, 1'b0, 1'b1);
        tick(2);
        ifc.btn_up = 1'b0;
        tick(2);

        // field change during down hold suppresses repeats
        ifc.btn_down = 1'b1;
        ev(1, 4'd8, 1'b0, 1'b1, 1'b1);
        tick(3);
        ifc.btn_left = 1'b1;
        ev(1, 4'd10, 1'b0, 1'b0, 1'b1);
        tick(1);
        ifc.btn_left = 1'b0;
        tick(12);
        ifc.btn_down = 1'b0;
        tick(2);
        ifc.btn_down = 1'b1;
        ev(1, 4'd10, 1'b0, 1'b1, 1'b1);
        tick(1);
        ifc.btn_down = 1'b0;
        tick(2);

        // prog exits
        ifc.btn_prog = 1'b1;
        ev(1, 4'd0, 1'b0, 1'b0, 1'b0);
        tick(1);
        ifc.btn_prog = 1'b0;
        tick(2);

        // date group entry then timeout 40 edges later
        ifc.group_sel = 2'd1;
        ifc.btn_prog = 1'b1;
        ev(1, 4'd4, 1'b0, 1'b0, 1'b1);
        ev(41, 4'd0, 1'b0, 1'b0, 1'b0);
        tick(1);
        ifc.btn_prog = 1'b0;
        tick(45);

        // invalid group stays idle
        ifc.group_sel = 2'd3;
        ifc.btn_prog = 1'b1;
        tick(1);
        ifc.btn_prog = 1'b0;
        tick(3);

        // buttons held through reset are ignored
        ifc.group_sel = 2'd0;
        ifc.btn_prog = 1'b1;
        ifc.btn_up = 1'b1;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(4);
        ifc.btn_prog = 1'b0;
        tick(2);
        ifc.btn_up = 1'b0;
        tick(2);

        // reset mid-repeat
        ifc.btn_prog = 1'b1;
        ev(1, 4'd1, 1'b0, 1'b0, 1'b1);
        tick(1);
        ifc.btn_prog = 1'b0;
        tick(1);
        ifc.btn_up = 1'b1;
        ev(1, 4'd1, 1'b1, 1'b0, 1'b1);
        ev(9, 4'd1, 1'b1, 1'b0, 1'b1);
        tick(10);
        reset = 1'b1;
        ev(1, 4'd0, 1'b0, 1'b0, 1'b0);
        tick(6);
        reset = 1'b0;
        tick(10);
        ifc.btn_up = 1'b0;
        tick(5);

        while (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_event got none want edge=%0d cnt=%0d up=%0b dn=%0b act=%0b",
                     e.at, e.cnt, e.up, e.dn, e.act);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/edit_field_sequencer.md
# edit_field_sequencer

Front-panel edit controller for the clock/date/timer adjust datapath. It turns debounced push-button levels into a field-select code (`en_count`) and single-cycle `enUP`/`enDOWN` step pulses with hold-to-repeat. These outputs drive the per-field 2-digit up/down adjust counters, including the timer-seconds counter selected by code 8. It runs in the system clock domain and replaces slow-clock sampling of raw button levels.

## Interface
- `HOLD_CYCLES`, default 50_000_000: cycles from the first step pulse to the first auto-repeat pulse (0.5 s at 100 MHz).
- `REPEAT_CYCLES`, default 26_000_000: cycles between auto-repeat pulses (~4 Hz).
- `TIMEOUT_CYCLES`, default 1_000_000_000: inactivity cycles before edit mode exits (10 s). All three parameters are ≥2 and fit in 32 bits.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `btn_prog` in 1: enter/exit edit mode. All `btn_*` inputs are debounced, synchronized levels.
- `btn_left` in 1: previous field.
- `btn_right` in 1: next field.
- `btn_up` in 1: increment selected field.
- `btn_down` in 1: decrement selected field.
- `group_sel` in 2: group to edit, sampled on entry. 0 = clock, 1 = date, 2 = timer, 3 = invalid.
- `en_count` out 4: selected field code; 0 = none.
- `enUP` out 1: one-cycle increment pulse.
- `enDOWN` out 1: one-cycle decrement pulse.
- `edit_active` out 1: high while in EDIT.

## Operation
- States are IDLE and EDIT. Registers: `group` (2 bits), `field_idx` (0..2), `hold_cnt`, `to_cnt` (32 bits each), `rep_armed` (1 bit), and the previous-value register for each button.
- Rising edge means the button is sampled 1 at this edge and its previous-value register holds 0.
- Field codes, for `field_idx` 0/1/2:
  - clock group: 1 SS, 2 MM, 3 HH;
  - date group: 4 DD, 5 MO, 6 YY;
  - timer group: 8 SS_T, 9 MM_T, 10 HH_T.
- In IDLE, `en_count` = 0 and `edit_active` = 0.
- In EDIT, `en_count` is the table code for (`group`, `field_idx`) and `edit_active` = 1.
- IDLE to EDIT: on a `btn_prog` rising edge with `group_sel` ≠ 3. This latches `group`, sets `field_idx` = 0 and clears `to_cnt`. With `group_sel` = 3 the block stays in IDLE.
- EDIT to IDLE happens on either event:
  - a `btn_prog` rising edge;
  - `to_cnt` reaching `TIMEOUT_CYCLES` − 1.
- A `btn_prog` edge has priority. In the cycle it occurs, any other button edge is ignored and no step pulse is issued.
- `btn_right` edge: `field_idx` + 1, wrapping 2 to 0. `btn_left` edge: `field_idx` − 1, wrapping 0 to 2. If both edges arrive in the same cycle, `field_idx` is unchanged.
- Any field change does three things: clears `rep_armed`, clears `hold_cnt`, and suppresses step pulses until both `btn_up` and `btn_down` are low.
- Step pulses (EDIT only, exactly one of up/down high):
  - A rising edge issues one pulse, sets `rep_armed` and clears `hold_cnt`.
  - While the button stays held and `rep_armed` is set, `hold_cnt` counts up. A pulse is issued when `hold_cnt` reaches `HOLD_CYCLES` − 1 for the first repeat, and `REPEAT_CYCLES` − 1 for later repeats. `hold_cnt` clears on each pulse.
- If `btn_up` and `btn_down` are both high, no pulse is issued and `rep_armed`/`hold_cnt` clear. A new step needs a fresh rising edge after one button is released.
- Releasing the active button clears `rep_armed` and `hold_cnt`.
- `to_cnt` clears on any button rising edge and on any step pulse; otherwise it increments while in EDIT. It is held at 0 in IDLE.
- `enUP` and `enDOWN` are never high together and never high in IDLE.

## Timing
- All outputs are registered.
- A button first sampled high at edge N produces a step pulse high for the single cycle after edge N. A field change is likewise visible on `en_count` after edge N.
- Auto-repeat: pulses at edges N + `HOLD_CYCLES`, then every `REPEAT_CYCLES` after that, while held.
- Timeout: the exit becomes visible `TIMEOUT_CYCLES` edges after the last activity.
- Reset values: `en_count` = 0, `enUP` = 0, `enDOWN` = 0, `edit_active` = 0, state IDLE, `field_idx` = 0, counters 0, `rep_armed` = 0.
- Button previous-value registers reset to 1. A button held through reset is therefore ignored until it is released.
- Reset asserted in EDIT, including during a repeat: outputs return to reset values at the next edge and no further pulses are issued.

## Test plan
Parameters for all scenarios: `HOLD_CYCLES` = 8, `REPEAT_CYCLES` = 4, `TIMEOUT_CYCLES` = 40.
- `group_sel` = 2 with a `btn_prog` press, then `btn_right` ×2, then `btn_right` again:
  - `en_count` goes 8, 10, 8;
  - `edit_active` = 1;
  - a second `btn_prog` press gives `en_count` = 0.
- EDIT with field 8, `btn_up` held 20 cycles starting at edge N: `enUP` pulses at N, N+8, N+12, N+16 (four one-cycle pulses), and `enDOWN` stays 0.
- `btn_up` and `btn_down` rise in the same cycle: no pulses. Releasing `btn_down` produces no pulse; releasing and re-pressing `btn_up` gives one `enUP` pulse.
- Hold `btn_down`, then press `btn_left` mid-hold: the field changes, no `enDOWN` pulses follow until `btn_down` is released, and the next press pulses once.
- Idle 40 cycles in EDIT: `en_count` = 0 and `edit_active` = 0 at edge 40. `group_sel` = 3 with a `btn_prog` press leaves the block in IDLE.
- `btn_up` held through reset and after its release: no `enUP` pulse. Reset asserted mid-repeat: all outputs are 0 on the next edge.
